// File: rtl/shot_sequencer.sv
// Light-gun / mouse shot sequencer: flash-frame detection for the gun,
// immediate result for the mouse, then a frame-counted cooldown.
module shot_sequencer #(
    parameter int unsigned COOLDOWN_FRAMES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    input  logic gun_trigger,
    input  logic gun_photodetector,
    input  logic gun_is_connected,
    input  logic mouse_left,
    input  logic mouse_on_target,
    output logic flash_black,
    output logic flash_target,
    output logic hit,
    output logic miss,
    output logic shot_fired,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        BLACK,
        TARGET,
        RESULT,
        COOLDOWN
    } state_t;

    localparam logic [3:0] CD = 4'(COOLDOWN_FRAMES);

    state_t state, state_n;

    logic       trig_s1, trig_s2, trig_d;
    logic       pd_s1, pd_s2;
    logic       ml_d;
    logic [1:0] prime;
    logic       armed_g, armed_m;
    logic       cheat, seen;
    logic [3:0] cnt;

    logic gun_ev, mouse_ev, trig_ev;
    logic result_hit, fire;
    logic flash_black_n, flash_target_n;
    logic hit_n, miss_n, shot_n, busy_n;

    // A button must be seen released after reset before it can fire;
    // prime waits out the synchronizer so its reset zeros don't arm it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_d  <= 1'b0;
            pd_s1   <= 1'b0;
            pd_s2   <= 1'b0;
            ml_d    <= 1'b0;
            prime   <= 2'b00;
            armed_g <= 1'b0;
            armed_m <= 1'b0;
        end else begin
            trig_s1 <= gun_trigger;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
            pd_s1   <= gun_photodetector;
            pd_s2   <= pd_s1;
            ml_d    <= mouse_left;
            prime   <= {prime[0], 1'b1};
            armed_g <= armed_g | (prime[1] & ~trig_s2);
            armed_m <= armed_m | ~mouse_left;
        end
    end

    assign gun_ev   = armed_g & trig_s2 & ~trig_d;
    assign mouse_ev = armed_m & mouse_left & ~ml_d;
    assign trig_ev  = gun_is_connected ? gun_ev : mouse_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (trig_ev)
                    state_n = gun_is_connected ? WAIT_FRAME : RESULT;
            end
            WAIT_FRAME: begin
                if (!gun_is_connected) state_n = IDLE;
                else if (frame_start)  state_n = BLACK;
            end
            BLACK: begin
                if (!gun_is_connected) state_n = IDLE;
                else if (frame_start)  state_n = TARGET;
            end
            TARGET: begin
                if (!gun_is_connected) state_n = IDLE;
                else if (frame_start)  state_n = RESULT;
            end
            RESULT: state_n = COOLDOWN;
            COOLDOWN: begin
                if (CD == 4'd0)
                    state_n = IDLE;
                else if (frame_start && cnt == 4'd1)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cheat <= 1'b0;
            seen  <= 1'b0;
            cnt   <= 4'd0;
        end else begin
            if (state == IDLE && state_n == WAIT_FRAME) begin
                cheat <= 1'b0;
                seen  <= 1'b0;
            end else begin
                if (state == BLACK && pd_s2)  cheat <= 1'b1;
                if (state == TARGET && pd_s2) seen  <= 1'b1;
            end
            if (state == RESULT)
                cnt <= CD;
            else if (state == COOLDOWN && frame_start && cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    // RESULT is entered from IDLE only on the mouse path.
    assign result_hit = (state == IDLE) ? mouse_on_target
                                        : ((seen | pd_s2) & ~cheat);

    always_comb begin
        fire           = (state_n == RESULT);
        flash_black_n  = (state_n == BLACK);
        flash_target_n = (state_n == TARGET);
        hit_n          = fire & result_hit;
        miss_n         = fire & ~result_hit;
        shot_n         = fire;
        busy_n         = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_black  <= 1'b0;
            flash_target <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            shot_fired   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            flash_black  <= flash_black_n;
            flash_target <= flash_target_n;
            hit          <= hit_n;
            miss         <= miss_n;
            shot_fired   <= shot_n;
            busy         <= busy_n;
        end
    end

endmodule

// File: tb/tb_shot_sequencer.sv
// Randomized shot scenarios checked cycle by cycle against expected
// output patterns derived from the shot rules.
module tb_shot_sequencer;

    localparam int CD = 2;

    // {flash_black, flash_target, hit, miss, shot_fired, busy}
    localparam logic [5:0] O_IDLE = 6'b000000;
    localparam logic [5:0] O_BUSY = 6'b000001;
    localparam logic [5:0] O_BLK  = 6'b100001;
    localparam logic [5:0] O_TGT  = 6'b010001;
    localparam logic [5:0] O_HIT  = 6'b001011;
    localparam logic [5:0] O_MISS = 6'b000111;

    logic clk = 1'b0;
    logic rst;
    logic frame_start;
    logic gun_trigger;
    logic gun_photodetector;
    logic gun_is_connected;
    logic mouse_left;
    logic mouse_on_target;
    logic flash_black, flash_target, hit, miss, shot_fired, busy;

    int n_chk = 0;
    int n_err = 0;

    shot_sequencer #(.COOLDOWN_FRAMES(CD)) dut (
        .clk               (clk),
        .rst               (rst),
        .frame_start       (frame_start),
        .gun_trigger       (gun_trigger),
        .gun_photodetector (gun_photodetector),
        .gun_is_connected  (gun_is_connected),
        .mouse_left        (mouse_left),
        .mouse_on_target   (mouse_on_target),
        .flash_black       (flash_black),
        .flash_target      (flash_target),
        .hit               (hit),
        .miss              (miss),
        .shot_fired        (shot_fired),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {flash_black, flash_target, hit, miss, shot_fired, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input logic fs);
        frame_start = fs;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic tick_chk(input logic fs, input string tag,
                            input logic [5:0] exp);
        tick(fs);
        chk(tag, 32'(obs()), 32'(exp));
    endtask

    // One flash frame; optional photodiode pulse kept clear of frame edges
    // so the synchronizer lag cannot smear it into a neighbouring frame.
    task automatic run_seg(input int n, input logic pd, input logic press,
                           input logic [5:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            gun_photodetector = pd && i >= 3 && i < n - 3;
            if (press && i == 2) gun_trigger = 1'b1;
            if (i == 6) gun_trigger = 1'b0;
            tick_chk(1'b0, tag, exp);
        end
        gun_photodetector = 1'b0;
    endtask

    task automatic cooldown(input logic press, input logic gun_mode);
        tick_chk(1'b0, "cd_entry", O_BUSY);
        if (CD == 0) tick_chk(1'b0, "cd_zero", O_IDLE);
        for (int k = 1; k <= CD; k++) begin
            int g;
            g = $urandom_range(10, 6);
            for (int i = 0; i < g; i++) begin
                if (press && k == 1 && i == 1) begin
                    if (gun_mode) gun_trigger = 1'b1;
                    else          mouse_left  = 1'b1;
                end
                if (press && k == 1 && i == 3) begin
                    if (gun_mode) gun_trigger = 1'b0;
                    else          mouse_left  = 1'b0;
                end
                tick_chk(1'b0, "cd_gap", O_BUSY);
            end
            tick_chk(1'b1, "cd_frame", (k < CD) ? O_BUSY : O_IDLE);
        end
        repeat (5) tick_chk(1'b0, "post_idle", O_IDLE);
    endtask

    task automatic gun_shot(input logic b, input logic t, input logic press_t,
                            input logic fs_edge, input logic abort,
                            input logic press_cd);
        gun_is_connected = 1'b1;
        gun_trigger = 1'b0;
        repeat (3) tick_chk(1'b0, "g_pre", O_IDLE);
        gun_trigger = 1'b1;
        tick_chk(1'b0, "g_sync1", O_IDLE);
        tick_chk(1'b0, "g_sync2", O_IDLE);
        // A frame_start in the edge cycle must not skip WAIT_FRAME.
        tick_chk(fs_edge, "g_arm", O_BUSY);
        gun_trigger = 1'b0;
        repeat ($urandom_range(6, 2)) tick_chk(1'b0, "g_wait", O_BUSY);
        tick_chk(1'b1, "g_f1", O_BLK);
        if (abort) begin
            repeat ($urandom_range(5, 1)) tick_chk(1'b0, "g_blk", O_BLK);
            gun_is_connected = 1'b0;
            tick_chk(1'b0, "g_abort", O_IDLE);
            repeat (4) tick_chk(1'b0, "g_abort_idle", O_IDLE);
            gun_is_connected = 1'b1;
            return;
        end
        run_seg($urandom_range(16, 8), b, 1'b0, O_BLK, "g_blk");
        tick_chk(1'b1, "g_f2", O_TGT);
        run_seg($urandom_range(16, 8), t, press_t, O_TGT, "g_tgt");
        tick_chk(1'b1, "g_result", (t && !b) ? O_HIT : O_MISS);
        cooldown(press_cd, 1'b1);
    endtask

    task automatic mouse_shot(input logic m, input logic flip,
                              input logic hold, input logic press_cd);
        gun_is_connected = 1'b0;
        mouse_left = 1'b0;
        repeat (3) tick_chk(1'b0, "m_pre", O_IDLE);
        mouse_on_target = m;
        mouse_left = 1'b1;
        tick_chk(1'b0, "m_fire", m ? O_HIT : O_MISS);
        mouse_on_target = 1'($urandom_range(1, 0));
        if (flip) gun_is_connected = 1'b1;
        if (!hold) mouse_left = 1'b0;
        cooldown(press_cd && !hold, 1'b0);
        mouse_left = 1'b0;
        mouse_on_target = 1'b0;
        gun_is_connected = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        gun_trigger = 1'b1;
        gun_photodetector = 1'b0;
        gun_is_connected = 1'b1;
        mouse_left = 1'b0;
        mouse_on_target = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(obs()), 32'(O_IDLE));
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        // Trigger held across reset release must not fire.
        repeat (10) tick_chk(1'b0, "rst_held", O_IDLE);
        gun_trigger = 1'b0;

        gun_shot(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        gun_shot(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mouse_shot(1'b1, 1'b0, 1'b0, 1'b0);
        gun_shot(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        gun_shot(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        mouse_shot(1'b0, 1'b1, 1'b1, 1'b0);

        for (int r = 0; r < 14; r++) begin
            int sel;
            sel = $urandom_range(5, 0);
            if (sel < 3)
                gun_shot(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                         1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                         1'b0, 1'($urandom_range(1, 0)));
            else if (sel == 3)
                gun_shot(1'b0, 1'b0, 1'b0, 1'($urandom_range(1, 0)),
                         1'b1, 1'b0);
            else
                mouse_shot(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        // Reset in the middle of TARGET with the trigger pressed again.
        gun_is_connected = 1'b1;
        gun_trigger = 1'b1;
        tick_chk(1'b0, "r_sync1", O_IDLE);
        tick_chk(1'b0, "r_sync2", O_IDLE);
        tick_chk(1'b0, "r_arm", O_BUSY);
        gun_trigger = 1'b0;
        repeat (3) tick_chk(1'b0, "r_wait", O_BUSY);
        tick_chk(1'b1, "r_f1", O_BLK);
        repeat (4) tick_chk(1'b0, "r_blk", O_BLK);
        tick_chk(1'b1, "r_f2", O_TGT);
        gun_trigger = 1'b1;
        repeat (3) tick_chk(1'b0, "r_tgt", O_TGT);
        #2 rst = 1'b1;
        #1 chk("rst_async", 32'(obs()), 32'(O_IDLE));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (8) tick_chk(1'b0, "r_held", O_IDLE);
        gun_trigger = 1'b0;
        repeat (3) tick_chk(1'b0, "r_release", O_IDLE);
        gun_trigger = 1'b1;
        tick_chk(1'b0, "r_resync1", O_IDLE);
        tick_chk(1'b0, "r_resync2", O_IDLE);
        tick_chk(1'b0, "r_repress", O_BUSY);
        gun_trigger = 1'b0;
        gun_is_connected = 1'b0;
        tick_chk(1'b0, "r_wait_abort", O_IDLE);
        gun_is_connected = 1'b1;
        repeat (3) tick_chk(1'b0, "r_end", O_IDLE);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
